// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  localparam int LAT_DEFAULT         = 2;
  localparam int DSTREAK_MAX_DEFAULT = 2;
  localparam int CNT_W               = 16;
  localparam int DATA_W              = 16;
  localparam int WAIT_W              = 3;
  localparam int STREAK_W            = 2;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit enable-increment counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] cntReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntReg <= '0;
    end else if (inc && (cntReg != 16'hFFFF)) begin
      cntReg <= cntReg + 16'd1;
    end
  end

  assign count = cntReg;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory port between an
// I-cache fill path and a D-cache path, with a bounded D-priority streak.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT         = LAT_DEFAULT,
  parameter int DSTREAK_MAX = DSTREAK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DSTREAK_MAX);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(LAT);

  arbState_t           stateReg, stateNext;
  logic                grantI, grantD;
  logic                ownerD;
  logic                cmdWr;
  logic [DATA_W-1:0]   cmdAddr, cmdWdata;
  logic [WAIT_W-1:0]   waitCnt;
  logic [STREAK_W-1:0] streak;
  logic [DATA_W-1:0]   iRdataReg, dRdataReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // I only overtakes a pending D once D has used up its streak allowance.
  always_comb begin
    stateNext = stateReg;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (i_req && (!d_req || (streak == STREAK_MAX))) grantI = 1'b1;
        else if (d_req)                                    grantD = 1'b1;
        if (grantI || grantD) stateNext = ISSUE;
      end
      ISSUE: stateNext = WAIT;
      WAIT:  if (waitCnt == WAIT_W'(1)) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerD    <= 1'b0;
      cmdWr     <= 1'b0;
      cmdAddr   <= '0;
      cmdWdata  <= '0;
      waitCnt   <= '0;
      streak    <= '0;
      iRdataReg <= '0;
      dRdataReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (grantI || grantD) begin
            ownerD   <= grantD;
            cmdWr    <= grantD & d_wr;
            cmdAddr  <= grantD ? d_addr : i_addr;
            cmdWdata <= grantD ? d_wdata : '0;
          end
          if (grantI) begin
            streak <= '0;
          end else if (grantD) begin
            if (!i_req)                    streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + STREAK_W'(1);
          end
        end
        ISSUE: waitCnt <= WAIT_LOAD;
        WAIT: begin
          waitCnt <= waitCnt - WAIT_W'(1);
          if (waitCnt == WAIT_W'(1)) begin
            if (ownerD) dRdataReg <= cmdWr ? '0 : mem_rdata;
            else        iRdataReg <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (stateReg == ISSUE);
  assign mem_wr    = mem_en & cmdWr;
  assign mem_addr  = mem_en ? cmdAddr  : '0;
  assign mem_wdata = mem_en ? cmdWdata : '0;
  assign i_done    = (stateReg == DONE) && !ownerD;
  assign d_done    = (stateReg == DONE) &&  ownerD;
  assign i_rdata   = iRdataReg;
  assign d_rdata   = dRdataReg;

  sat_cnt16 uICnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grantI),
    .count (i_grant_cnt)
  );

  sat_cnt16 uDCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grantD),
    .count (d_grant_cnt)
  );

endmodule
